tea_scheduler: RTL and testbench

Round-robin scheduler that shares one iterative TEA engine among `NUM_REQ` requesters. Each requester hands over a 64-bit block, a 128-bit key and a mode bit (encrypt or decrypt). The scheduler latches one request and runs `ROUNDS` full TEA cycles, one per clock, on a single combinational round datapath. It then returns the result with the requester ID on a single response channel. It sits between the requester ports and the `tea_round` datapath, and is the only block that drives that datapath.

---
 rtl/tea_pkg.sv | 26 ++
 rtl/tea_round.sv | 46 ++++
 rtl/tea_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_tea_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// tea_pkg
//   Shared definitions for the TEA scheduler and its round datapath:
//   the TEA key-schedule constant, the scheduler state encoding and the
//   per-half mixing function used by both encrypt and decrypt rounds.
package tea_pkg;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb), all modulo 2^32,
  // logical shifts.
  function automatic logic [31:0] tea_f(
    input logic [31:0] v,
    input logic [31:0] ka,
    input logic [31:0] kb,
    input logic [31:0] s
  );
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_round.sv
// tea_round
//   One full TEA cycle (both halves), purely combinational. It carries no
//   state, so an unrolled core can chain several copies of it.
//
// Ports
//   v0_i, v1_i   : current block halves
//   k0_i..k3_i   : key words
//   sum_i        : current sum register value (before this round)
//   decrypt_i    : 1 = inverse round, 0 = forward round
//   v0_o, v1_o   : block halves after this round
module tea_round
  import tea_pkg::*;
(
  input  logic [31:0] v0_i,
  input  logic [31:0] v1_i,
  input  logic [31:0] k0_i,
  input  logic [31:0] k1_i,
  input  logic [31:0] k2_i,
  input  logic [31:0] k3_i,
  input  logic [31:0] sum_i,
  input  logic        decrypt_i,
  output logic [31:0] v0_o,
  output logic [31:0] v1_o
);

  logic [31:0] s_enc;
  logic [31:0] v0_enc;
  logic [31:0] v1_enc;
  logic [31:0] v0_dec;
  logic [31:0] v1_dec;

  // Encrypt advances the sum before mixing; decrypt mixes with the sum as
  // it stands and the caller steps it back afterwards.
  assign s_enc  = sum_i + DELTA;
  assign v0_enc = v0_i + tea_f(v1_i, k0_i, k1_i, s_enc);
  assign v1_enc = v1_i + tea_f(v0_enc, k2_i, k3_i, s_enc);

  // Decrypt undoes the halves in reverse order: v1 first, then v0 using
  // the recovered v1.
  assign v1_dec = v1_i - tea_f(v0_i, k2_i, k3_i, sum_i);
  assign v0_dec = v0_i - tea_f(v1_dec, k0_i, k1_i, sum_i);

  assign v0_o = decrypt_i ? v0_dec : v0_enc;
  assign v1_o = decrypt_i ? v1_dec : v1_enc;

endmodule

// File: rtl/tea_scheduler.sv
// tea_scheduler
//   Round-robin front end that shares a single iterative TEA engine among
//   NUM_REQ requesters. One request is latched, ROUNDS TEA cycles run at one
//   per clock through tea_round, and the result is returned with the owning
//   requester's index on a single valid/ready response channel.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | arbiter live, req_ready offered to the round-robin winner
//   RUN   | one TEA cycle per clock, round counter advancing
//   DONE  | response held on resp_* until resp_ready
//
// Ports
//   clk, reset_n          : clock, synchronous active-low reset
//   req_valid/req_ready   : per-requester handshake, req_ready one-hot or 0
//   req_block             : 64 bits per requester, v0 in [63:32], v1 in [31:0]
//   req_key               : 128 bits per requester, k0 in [127:96] .. k3 in [31:0]
//   req_decrypt           : per-requester mode, 1 = decrypt
//   resp_valid/resp_ready : response handshake
//   resp_block, resp_id   : result and the index of the requester it belongs to
//   busy                  : high while a block is in RUN or DONE
module tea_scheduler
  import tea_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int ROUNDS  = 32,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [64*NUM_REQ-1:0]  req_block,
  input  logic [128*NUM_REQ-1:0] req_key,
  input  logic [NUM_REQ-1:0]     req_decrypt,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [63:0]            resp_block,
  output logic [ID_W-1:0]        resp_id,
  output logic                   busy
);

  // Starting sum for decrypt is where encrypt leaves it after ROUNDS steps.
  localparam logic [31:0] SUM_DEC  = 32'(DELTA * 32'(ROUNDS));
  localparam logic [6:0]  LAST_CNT = 7'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [31:0]      sum_q, sum_d;
  logic [31:0]      v0_q, v0_d;
  logic [31:0]      v1_q, v1_d;
  logic [127:0]     key_q, key_d;
  logic             dec_q, dec_d;
  logic [63:0]      resp_block_q, resp_block_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;

  logic [NUM_REQ-1:0] rot_valid;
  logic [ID_W:0]      first_k;
  logic [ID_W:0]      grant_sum;
  logic [ID_W:0]      ptr_sum;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               accept;
  logic               last_round;
  logic               resp_fire;

  logic [63:0]  sel_block;
  logic [127:0] sel_key;
  logic         sel_dec;

  logic [31:0] rnd_v0;
  logic [31:0] rnd_v1;

  // ---------------------------------------------------------------------
  // Round-robin arbiter: rotate req_valid so rr_ptr sits at bit 0, take
  // the lowest set bit, then rotate the offset back to an absolute index.
  // ---------------------------------------------------------------------
  always_comb begin
    rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
    first_k   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) first_k = (ID_W+1)'(k);
    end
    grant_sum = {1'b0, rr_ptr_q} + first_k;
    if (grant_sum >= (ID_W+1)'(NUM_REQ)) begin
      grant_sum = grant_sum - (ID_W+1)'(NUM_REQ);
    end
    grant_idx = grant_sum[ID_W-1:0];
    grant_any = |req_valid;
  end

  always_comb begin
    sel_block = '0;
    sel_key   = '0;
    sel_dec   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_block = req_block[64*i +: 64];
        sel_key   = req_key[128*i +: 128];
        sel_dec   = req_decrypt[i];
      end
    end
  end

  // Whenever any request is pending in IDLE, the winner's valid is high by
  // construction, so the handshake reduces to this.
  assign accept     = (state_q == IDLE) && grant_any;
  assign last_round = (state_q == RUN) && (cnt_q == LAST_CNT);
  assign resp_fire  = (state_q == DONE) && resp_ready;

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = RUN;
      RUN:     if (last_round) state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && grant_any && (grant_idx == ID_W'(i));
    end
    resp_valid = (state_q == DONE);
    busy       = (state_q != IDLE);
    resp_block = resp_block_q;
    resp_id    = resp_id_q;
  end

  // ---------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------
  tea_round u_round (
    .v0_i      (v0_q),
    .v1_i      (v1_q),
    .k0_i      (key_q[127:96]),
    .k1_i      (key_q[95:64]),
    .k2_i      (key_q[63:32]),
    .k3_i      (key_q[31:0]),
    .sum_i     (sum_q),
    .decrypt_i (dec_q),
    .v0_o      (rnd_v0),
    .v1_o      (rnd_v1)
  );

  always_comb begin
    v0_d         = v0_q;
    v1_d         = v1_q;
    key_d        = key_q;
    dec_d        = dec_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    resp_block_d = resp_block_q;
    resp_id_d    = resp_id_q;
    rr_ptr_d     = rr_ptr_q;
    ptr_sum      = '0;

    if (accept) begin
      v0_d  = sel_block[63:32];
      v1_d  = sel_block[31:0];
      key_d = sel_key;
      dec_d = sel_dec;
      id_d  = grant_idx;
      cnt_d = '0;
      sum_d = sel_dec ? SUM_DEC : 32'd0;
    end else if (state_q == RUN) begin
      v0_d  = rnd_v0;
      v1_d  = rnd_v1;
      cnt_d = cnt_q + 7'd1;
      // Same sum sequence the round used internally (encrypt) or the next
      // one it will need (decrypt).
      sum_d = dec_q ? (sum_q - DELTA) : (sum_q + DELTA);
      if (last_round) begin
        resp_block_d = {rnd_v0, rnd_v1};
        resp_id_d    = id_q;
      end
    end

    // Pointer moves only when the response is taken, so a stalled
    // response never lets the arbiter rotate.
    if (resp_fire) begin
      ptr_sum = {1'b0, id_q} + (ID_W+1)'(1);
      if (ptr_sum == (ID_W+1)'(NUM_REQ)) ptr_sum = '0;
      rr_ptr_d = ptr_sum[ID_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v0_q         <= '0;
      v1_q         <= '0;
      key_q        <= '0;
      dec_q        <= 1'b0;
      id_q         <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      resp_block_q <= '0;
      resp_id_q    <= '0;
      rr_ptr_q     <= '0;
    end else begin
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      key_q        <= key_d;
      dec_q        <= dec_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      resp_block_q <= resp_block_d;
      resp_id_q    <= resp_id_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_tea_scheduler.sv
// tb_tea_scheduler
//   Directed bench for tea_scheduler: a default build (2 requesters, 32
//   rounds) and a 3-requester single-round build. Expected values come from
//   constants and a loop-based reference TEA model.
module tb_tea_scheduler;

  localparam logic [31:0] DLT = 32'h9E3779B9;
  localparam logic [63:0] ZERO_CT = 64'h41EA3A0A_94BAA940;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic [1:0]   req_valid, req_ready, req_dec;
  logic [127:0] req_block;
  logic [255:0] req_key;
  logic         resp_valid, resp_ready, busy;
  logic [63:0]  resp_block;
  logic         resp_id;

  logic [2:0]   req_valid_3, req_ready_3, req_dec_3;
  logic [191:0] req_block_3;
  logic [383:0] req_key_3;
  logic         resp_valid_3, resp_ready_3, busy_3;
  logic [63:0]  resp_block_3;
  logic [1:0]   resp_id_3;

  int n_vec = 0;
  int n_err = 0;

  tea_scheduler u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_block   (req_block),
    .req_key     (req_key),
    .req_decrypt (req_dec),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_block  (resp_block),
    .resp_id     (resp_id),
    .busy        (busy)
  );

  tea_scheduler #(.NUM_REQ(3), .ROUNDS(1)) u_dut3 (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid_3),
    .req_ready   (req_ready_3),
    .req_block   (req_block_3),
    .req_key     (req_key_3),
    .req_decrypt (req_dec_3),
    .resp_valid  (resp_valid_3),
    .resp_ready  (resp_ready_3),
    .resp_block  (resp_block_3),
    .resp_id     (resp_id_3),
    .busy        (busy_3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] tea_ref(input logic [63:0] blk, input logic [127:0] key,
                                          input logic dec, input int rounds);
    logic [31:0] v0, v1, s, k0, k1, k2, k3;
    v0 = blk[63:32];  v1 = blk[31:0];
    k0 = key[127:96]; k1 = key[95:64]; k2 = key[63:32]; k3 = key[31:0];
    if (!dec) begin
      s = 32'd0;
      for (int r = 0; r < rounds; r++) begin
        s  = s + DLT;
        v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
        v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
      end
    end else begin
      s = DLT * 32'(rounds);
      for (int r = 0; r < rounds; r++) begin
        v1 = v1 - (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
        v0 = v0 - (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
        s  = s - DLT;
      end
    end
    return {v0, v1};
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send(input int id, input logic [63:0] blk, input logic [127:0] key, input logic dec);
    int t;
    req_block[64*id +: 64]  = blk;
    req_key[128*id +: 128]  = key;
    req_dec[id]             = dec;
    req_valid[id]           = 1'b1;
    #1;
    t = 0;
    while (!req_ready[id] && t < 100) begin
      @(negedge clk); #1; t++;
    end
    chk("grant_wait", (t < 100), 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!resp_valid && lat < 200);
    chk("resp_wait", resp_valid, 1);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic xfer(input int id, input logic [63:0] blk, input logic [127:0] key, input logic dec,
                      input string tag, input logic [63:0] exp, output int lat);
    send(id, blk, key, dec);
    wait_resp(lat);
    chk({tag, "_blk"}, resp_block, exp);
    chk({tag, "_id"}, resp_id, id);
    finish_resp();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, g, lat, seen;
    int exp_g3[4];
    logic [63:0]  b, c, exp_bp;
    logic [127:0] k;

    reset_n = 1'b0;
    req_valid = '0; req_dec = '0; req_block = '0; req_key = '0; resp_ready = 1'b0;
    req_valid_3 = '0; req_dec_3 = '0; req_block_3 = '0; req_key_3 = '0; resp_ready_3 = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_block", resp_block, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst3_busy", busy_3, 0);
    chk("rst3_valid", resp_valid_3, 0);

    // Both requesters hold valid for 6 blocks: grants alternate from 0
    req_block  = {ZERO_CT, 64'h0};
    req_key    = '0;
    req_dec    = 2'b10;
    resp_ready = 1'b1;
    req_valid  = 2'b11;
    for (int n = 0; n < 6; n++) begin
      #1; t = 0;
      while (req_ready == 2'b00 && t < 100) begin
        @(negedge clk); #1; t++;
      end
      chk("alt_onehot", $countones(req_ready), 1);
      g = req_ready[1] ? 1 : 0;
      chk("alt_grant", g, n % 2);
      t = 0;
      do begin
        @(negedge clk); t++;
      end while (!resp_valid && t < 200);
      chk("alt_valid", resp_valid, 1);
      chk("alt_id", resp_id, g);
      chk("alt_blk", resp_block, (g == 1) ? 64'h0 : ZERO_CT);
      if (n == 5) req_valid = 2'b00;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);

    // Known-answer encrypt / decrypt with latency
    xfer(0, 64'h0, 128'h0, 1'b0, "kat_enc", ZERO_CT, lat);
    chk("kat_enc_lat", lat, 33);
    xfer(0, ZERO_CT, 128'h0, 1'b1, "kat_dec", 64'h0, lat);
    chk("kat_dec_lat", lat, 33);

    // Backpressure: hold DONE 20 cycles with requester 0 waiting
    b = 64'h01234567_89ABCDEF;
    k = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    exp_bp = tea_ref(b, k, 1'b0, 32);
    send(1, b, k, 1'b0);
    wait_resp(lat);
    req_block[63:0] = 64'hDEADBEEF_00000001;
    req_valid[0] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_blk", resp_block, exp_bp);
      chk("bp_id", resp_id, 1);
      chk("bp_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_rel_busy", busy, 0);
    chk("bp_rel_valid", resp_valid, 0);
    chk("bp_rel_ready", req_ready, 2'b01);
    req_valid[0] = 1'b0;
    @(negedge clk);

    // Reset at round 10 of RUN
    b = 64'hCAFEF00D_12345678;
    k = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    send(0, b, k, 1'b0);
    repeat (10) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_blk", resp_block, 0);
    chk("mid_rst_id", resp_id, 0);
    chk("mid_rst_ready", req_ready, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("mid_no_resp", seen, 0);
    xfer(0, b, k, 1'b0, "mid_after", tea_ref(b, k, 1'b0, 32), lat);

    // Random round trips
    for (int i = 0; i < 1000; i++) begin
      b = {$urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      c = tea_ref(b, k, 1'b0, 32);
      xfer(i % 2, b, k, 1'b0, "rt_enc", c, lat);
      xfer((i + 1) % 2, c, k, 1'b1, "rt_dec", b, lat);
    end

    // Single-round, 3-requester build: grants 0,1,2,0 with all valid
    exp_g3 = '{0, 1, 2, 0};
    req_block_3 = {64'h89ABCDEF_01234567, 64'h00000001_00000002, 64'h0};
    req_key_3   = {128'h1, 128'h00000000_11111111_22222222_33333333, 128'h0};
    req_dec_3   = 3'b100;
    resp_ready_3 = 1'b1;
    req_valid_3  = 3'b111;
    for (int n = 0; n < 4; n++) begin
      #1; t = 0;
      while (req_ready_3 == 3'b000 && t < 100) begin
        @(negedge clk); #1; t++;
      end
      chk("r3_onehot", $countones(req_ready_3), 1);
      g = 0;
      for (int i = 0; i < 3; i++) if (req_ready_3[i]) g = i;
      chk("r3_grant", g, exp_g3[n]);
      lat = 0;
      do begin
        @(negedge clk); lat++;
      end while (!resp_valid_3 && lat < 50);
      chk("r3_lat", lat, 2);
      chk("r3_id", resp_id_3, g);
      chk("r3_blk", resp_block_3,
          tea_ref(req_block_3[64*g +: 64], req_key_3[128*g +: 128], req_dec_3[g], 1));
      if (n == 3) req_valid_3 = 3'b000;
    end
    @(posedge clk); #1;
    resp_ready_3 = 1'b0;
    @(negedge clk);
    chk("r3_idle", busy_3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
